// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot column strobes, ghost rejection, press/release debounce, buffered code.
// Define KEYPAD_SCAN_FIFO_EN to replace the single output register with a 4-entry FIFO.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | columns off, waiting for enable
// S_SCAN  | drive column ptr for DWELL cycles, sample rows on last one
// S_PRESS | one key seen, counting stable cycles before accepting it
// S_HOLD  | key accepted, counting released cycles before rescanning
module keypad_scan_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DWELL    = 2,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = $clog2(ROWS*COLS)
) (
    input  logic              slow_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overrun
);

    localparam int PTR_W = $clog2(COLS);
    localparam int DW_W  = $clog2(DWELL);
    localparam int RI_W  = $clog2(ROWS);
    localparam int DB_W  = 8;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PRESS, S_HOLD} state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt, ptr_inc;
    logic [DW_W-1:0]   dwell_cnt, dwell_nxt;
    logic [DB_W-1:0]   deb_cnt, deb_nxt;
    logic [ROWS-1:0]   row_lat, row_nxt;
    logic [RI_W-1:0]   row_idx;
    logic [CODE_W-1:0] push_code;
    logic              row_one_hot, row_match, deb_done, push, pop;

    assign row_one_hot = (row_in != '0) && ((row_in & (row_in - ROWS'(1))) == '0);
    assign row_match   = (row_in == row_lat);
    assign deb_done    = (deb_cnt == DB_W'(DEBOUNCE-1));
    assign ptr_inc     = (ptr == PTR_W'(COLS-1)) ? '0 : ptr + PTR_W'(1);
    assign pop         = key_valid & key_ready;

    always_comb begin
        row_idx = '0;
        for (int r = 0; r < ROWS; r++)
            if (row_lat[r]) row_idx = RI_W'(r);
    end

    assign push_code = CODE_W'(int'(row_idx) * COLS + int'(ptr));

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            row_lat   <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            dwell_cnt <= dwell_nxt;
            deb_cnt   <= deb_nxt;
            row_lat   <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        dwell_nxt = dwell_cnt;
        deb_nxt   = deb_cnt;
        row_nxt   = row_lat;
        push      = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
            ptr_nxt   = '0;
            dwell_nxt = '0;
            deb_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_SCAN;
                    ptr_nxt   = '0;
                    dwell_nxt = DW_W'(DWELL-1);
                end
                S_SCAN: begin
                    if (dwell_cnt != '0) begin
                        dwell_nxt = dwell_cnt - DW_W'(1);
                    end else if (row_one_hot) begin
                        row_nxt   = row_in;
                        deb_nxt   = '0;
                        state_nxt = S_PRESS;
                    end else begin
                        ptr_nxt   = ptr_inc;
                        dwell_nxt = DW_W'(DWELL-1);
                    end
                end
                S_PRESS: begin
                    if (!row_match) begin
                        state_nxt = S_SCAN;
                        ptr_nxt   = ptr_inc;
                        dwell_nxt = DW_W'(DWELL-1);
                    end else if (deb_done) begin
                        push      = 1'b1;
                        deb_nxt   = '0;
                        state_nxt = S_HOLD;
                    end else begin
                        deb_nxt = deb_cnt + DB_W'(1);
                    end
                end
                S_HOLD: begin
                    // Only a fully released matrix counts; other keys during hold are ignored.
                    if (row_in != '0) begin
                        deb_nxt = '0;
                    end else if (deb_done) begin
                        deb_nxt   = '0;
                        state_nxt = S_SCAN;
                        ptr_nxt   = '0;
                        dwell_nxt = DW_W'(DWELL-1);
                    end else begin
                        deb_nxt = deb_cnt + DB_W'(1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        col_out  = '0;
        key_held = 1'b0;
        if (enable && state != S_IDLE) col_out = COLS'(1) << ptr;
        if (enable && state == S_HOLD) key_held = 1'b1;
    end

`ifdef KEYPAD_SCAN_FIFO_EN
    logic [CODE_W-1:0] fifo_mem [4];
    logic [1:0]        rd_ptr, wr_ptr;
    logic [2:0]        count;
    logic              fifo_full, accept;

    assign fifo_full = (count == 3'd4);
    assign accept    = push && (!fifo_full || pop);
    assign key_valid = (count != 3'd0);
    assign key_code  = fifo_mem[rd_ptr];

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && fifo_full && !pop;
            if (accept) begin
                fifo_mem[wr_ptr] <= push_code;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [CODE_W-1:0] code_q;
    logic              valid_q;

    assign key_code  = code_q;
    assign key_valid = valid_q;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && valid_q && !pop;
            if (push) begin
                if (!valid_q || pop) begin
                    code_q  <= push_code;
                    valid_q <= 1'b1;
                end
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a simple keypad model (one column, chosen row bits).
// Build with KEYPAD_SCAN_FIFO_EN to check the FIFO variant of the overrun test.
module tb_keypad_scan_ctrl;

    logic       slow_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    logic [3:0] press_col;
    logic [3:0] press_rows;

    int n_checks = 0;
    int n_errors = 0;

    keypad_scan_ctrl #(.ROWS(4), .COLS(4), .DWELL(2), .DEBOUNCE(4)) dut (
        .slow_clk  (slow_clk),
        .rst       (rst),
        .enable    (enable),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 slow_clk = ~slow_clk;

    // Rows only respond while the pressed key's column is strobed.
    assign row_in = ((col_out & press_col) != 4'b0) ? press_rows : 4'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic wait_col(input logic [3:0] target, input int budget);
        int n = 1;
        tick();
        while (col_out !== target && n < budget) begin
            tick();
            n++;
        end
        check("wait_col", col_out, target);
    endtask

    task automatic wait_held(input logic exp, input int budget);
        int n = 0;
        while (key_held !== exp && n < budget) begin
            tick();
            n++;
        end
        check("wait_held", key_held, exp);
    endtask

    logic [3:0] exp_seq [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        key_ready  = 1'b0;
        press_col  = 4'b0;
        press_rows = 4'b0;
        tick();
        tick();
        check("rst_col", col_out, 0);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        check("rst_ovr", overrun, 0);

        // Free-running scan, no keys
        rst    = 1'b0;
        enable = 1'b1;
        check("idle_col", col_out, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("scan_col", col_out, exp_seq[i]);
            check("scan_valid", key_valid, 0);
        end

        // Key 9: row 2, column 1, consumer ready
        press_col  = 4'b0010;
        press_rows = 4'b0100;
        key_ready  = 1'b1;
        wait_col(4'b0010, 20);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("press_lat", key_valid, 0);
        end
        tick();
        check("k9_valid", key_valid, 1);
        check("k9_code", key_code, 9);
        check("k9_held", key_held, 1);
        check("k9_col", col_out, 4'b0010);
        tick();
        check("k9_pop", key_valid, 0);
        check("k9_held2", key_held, 1);
        press_rows = 4'b0;
        for (int k = 0; k < 3; k++) tick();
        check("rel_held", key_held, 1);
        tick();
        check("rel_done", key_held, 0);
        check("rel_col", col_out, 4'b0001);

        // Short press: 3 stable cycles after the sample
        press_col  = 4'b0010;
        press_rows = 4'b0001;
        wait_col(4'b0010, 20);
        for (int k = 0; k < 4; k++) tick();
        check("short_held", key_held, 0);
        tick();
        press_rows = 4'b0;
        tick();
        check("short_col", col_out, 4'b0100);
        check("short_valid", key_valid, 0);

        // Ghost pattern on column 3
        press_col  = 4'b1000;
        press_rows = 4'b0110;
        wait_col(4'b1000, 20);
        tick();
        tick();
        check("ghost_col", col_out, 4'b0001);
        for (int k = 0; k < 16; k++) tick();
        check("ghost_valid", key_valid, 0);
        check("ghost_held", key_held, 0);
        press_rows = 4'b0;

        // Two codes with consumer stalled
        key_ready  = 1'b0;
        press_col  = 4'b0001;
        press_rows = 4'b0001;
        wait_held(1'b1, 40);
        check("c0_valid", key_valid, 1);
        check("c0_code", key_code, 0);
        press_rows = 4'b0;
        wait_held(1'b0, 20);
        press_col  = 4'b1000;
        press_rows = 4'b1000;
        wait_held(1'b1, 40);
`ifdef KEYPAD_SCAN_FIFO_EN
        check("c15_ovr", overrun, 0);
`else
        check("c15_ovr", overrun, 1);
`endif
        check("c15_code_kept", key_code, 0);
        tick();
        check("ovr_pulse_end", overrun, 0);
        press_rows = 4'b0;
        wait_held(1'b0, 20);
        key_ready = 1'b1;
        check("drain0_valid", key_valid, 1);
        check("drain0_code", key_code, 0);
        tick();
`ifdef KEYPAD_SCAN_FIFO_EN
        check("drain1_valid", key_valid, 1);
        check("drain1_code", key_code, 15);
        tick();
`endif
        check("drain_empty", key_valid, 0);

        // Pending code, then async reset in PRESS
        key_ready  = 1'b0;
        press_col  = 4'b0010;
        press_rows = 4'b0001;
        wait_held(1'b1, 40);
        check("pend_valid", key_valid, 1);
        check("pend_code", key_code, 1);
        press_rows = 4'b0;
        wait_held(1'b0, 20);
        press_col  = 4'b0100;
        press_rows = 4'b0010;
        wait_col(4'b0100, 20);
        tick();
        tick();
        check("press_col_pre", col_out, 4'b0100);
        rst = 1'b1;
        #1;
        check("arst_col", col_out, 0);
        check("arst_valid", key_valid, 0);
        check("arst_code", key_code, 0);
        check("arst_held", key_held, 0);
        check("arst_ovr", overrun, 0);
        press_rows = 4'b0;
        tick();
        rst    = 1'b0;
        enable = 1'b1;

        // Drop enable during HOLD
        press_col  = 4'b0010;
        press_rows = 4'b0001;
        wait_held(1'b1, 40);
        check("hold_valid", key_valid, 1);
        enable = 1'b0;
        #1;
        check("dis_col_now", col_out, 0);
        check("dis_held_now", key_held, 0);
        tick();
        check("dis_col", col_out, 0);
        check("dis_held", key_held, 0);
        check("dis_valid", key_valid, 1);
        check("dis_code", key_code, 1);
        press_rows = 4'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scan controller: drives one-hot column strobes, samples the row inputs, debounces a single pressed key and delivers its linear code through a valid/ready handshake. It is the sequential successor to the combinational row decoder. It owns column sequencing, ghost rejection, press/release debounce and output buffering. It sits between the keypad pins (after the row synchronisers) and the display/command logic, clocked by the divided scan clock.

## Interface
Parameters:
- ROWS, 4: number of row inputs (2..8).
- COLS, 4: number of column strobes (2..8).
- DWELL, 2: cycles each column is driven; rows are sampled on the last cycle (≥2).
- DEBOUNCE, 4: consecutive stable cycles required for press and for release (1..255).
- CODE_W, $clog2(ROWS*COLS): key code width (derived; do not override).

Ports:
- slow_clk  in  1  scan clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; low forces IDLE.
- row_in  in  ROWS  synchronised row levels; 1 = key closed on the driven column.
- col_out  out  COLS  one-hot column drive, or all-zero.
- key_code  out  CODE_W  code = row_idx*COLS + col_idx; valid while key_valid=1.
- key_valid  out  1  code available.
- key_ready  in  1  consumer accepts when key_valid & key_ready.
- key_held  out  1  high while a debounced key is down.
- overrun  out  1  one-cycle pulse when a debounced code is dropped.

## Operation
- Reset: state IDLE, col pointer 0, col_out=0, key_code=0, key_valid=0, key_held=0, overrun=0, debounce and dwell counters 0, buffer empty.
- IDLE: col_out=0. When enable=1, go to SCAN with col pointer 0.
- SCAN: col_out = 1<<ptr for DWELL cycles. On the last dwell cycle, sample row_in:
  - 0 bits set: advance ptr (COLS-1 wraps to 0) and restart dwell.
  - Exactly 1 bit set: latch row_idx and col_idx, clear the debounce counter, go to PRESS; the column stays driven.
  - ≥2 bits set (ghost or multi-press): treat as no key and advance ptr.
- PRESS: each cycle, if row_in equals the latched one-hot row, increment the counter. Any mismatch returns to SCAN at ptr+1.
  - When the counter reaches DEBOUNCE, push the code into the output buffer, set key_held, go to HOLD.
- HOLD: column stays driven. Count consecutive cycles with row_in == 0; any nonzero cycle clears the count.
  - At DEBOUNCE, clear key_held and go to SCAN with ptr 0.
  - A second key pressed during HOLD is ignored.
- enable=0 in any state: IDLE on the next edge; col_out=0 and key_held=0 that cycle. The buffer and key_valid are preserved.
- Output buffer, single register (macro off):
  - A push when empty sets key_valid.
  - A push when full, without a pop in the same cycle, drops the new code and pulses overrun.
  - A push and a pop in the same cycle loads the new code; key_valid stays 1 and there is no overrun.
- Handshake rules:
  - key_code must be stable while key_valid=1 and key_ready=0.
  - key_ready while key_valid=0 has no effect.

## Timing
- Column period is DWELL cycles; a full scan is DWELL*COLS cycles.
- Press latency, from the sample cycle detecting the key to key_valid=1: DEBOUNCE+1 cycles.
  - The row must remain stable through those DEBOUNCE cycles after the sample.
- Release latency, from the first row_in==0 cycle to key_held=0: DEBOUNCE cycles.
- Pop takes effect on the edge where key_valid & key_ready; key_valid falls the next cycle if the buffer empties.
- overrun is asserted in the cycle after the dropped push.
- Asynchronous rst mid-scan clears everything immediately, including a pending code.

## Configuration
- KEYPAD_SCAN_FIFO_EN defined: the output buffer is a 4-entry FIFO.
  - key_code is the oldest entry and key_valid means not empty.
  - overrun pulses only on a push to a full FIFO without a simultaneous pop.
  - Simultaneous push and pop is allowed in every occupancy.
- Not defined: single-register buffer as in Operation.

## Test plan
Defaults ROWS=COLS=4, DWELL=2, DEBOUNCE=4.
- Reset then enable=1, no keys → col_out cycles 0001, 0010, 0100, 1000, 0001, each for 2 cycles; key_valid stays 0.
- Hold row_in=0100 while col_out=0010 for ≥8 cycles, key_ready=1 → key_code=9 (2*4+1), key_valid for exactly one cycle, key_held=1 until 4 cycles after release.
- Press a key for only 3 cycles after the sample, then release → no key_valid; scan resumes at col_out=0100.
- row_in=0110 on any column → treated as ghost; scan continues and no code is produced.
- key_ready=0 with two separate debounced presses (codes 0 and 15):
  - macro off → key_code stays 0 and overrun pulses once.
  - macro on → both codes pop in order 0 then 15 after key_ready=1.
- Assert rst during PRESS, and separately drop enable during HOLD → all outputs return to reset values within one edge; with enable low, col_out=0 and key_valid is retained.
